// File: rtl/alu_2bit_pkg.sv
// Shared types and widths for the registered 2-bit ALU.
// The result is one bit wider than the operands to hold the carry or borrow.
package alu_2bit_pkg;

  localparam int ALU_WIDTH = 2;
  localparam int RES_WIDTH = ALU_WIDTH + 1;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_OR  = 2'b11
  } op_e;

endpackage

// File: rtl/alu_2bit_core.sv
// Combinational ALU datapath: add/sub/and/or on zero-extended operands, plus zero flag.
// Unknown opcodes fall into the default arm, so the result is zero and carries no X.
module alu_2bit_core
  import alu_2bit_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       Op,
  output logic [WIDTH:0]   result,
  output logic             zero
);

  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] b_ext;

  assign a_ext = {1'b0, A};
  assign b_ext = {1'b0, B};

  // Subtraction wraps modulo 2^(WIDTH+1), so the MSB is set exactly when A < B.
  always_comb begin
    result = '0;
    case (Op)
      OP_ADD:  result = a_ext + b_ext;
      OP_SUB:  result = a_ext - b_ext;
      OP_AND:  result = a_ext & b_ext;
      OP_OR:   result = a_ext | b_ext;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_2bit.sv
// Registered ALU: inputs sampled when in_valid, result/zero/out_valid one cycle later.
// No backpressure; Y and zero hold between valid inputs, out_valid follows in_valid.
module alu_2bit
  import alu_2bit_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       Op,
  output logic             out_valid,
  output logic [WIDTH:0]   Y,
  output logic             zero
);

  logic [WIDTH:0] core_result;
  logic           core_zero;

  logic [WIDTH:0] y_d, y_q;
  logic           zero_d, zero_q;
  logic           valid_d, valid_q;

  alu_2bit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .A      (A),
    .B      (B),
    .Op     (Op),
    .result (core_result),
    .zero   (core_zero)
  );

  always_comb begin
    y_d     = y_q;
    zero_d  = zero_q;
    valid_d = in_valid;
    if (in_valid) begin
      y_d    = core_result;
      zero_d = core_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      y_q     <= y_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
    end
  end

  assign Y         = y_q;
  assign zero      = zero_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_2bit.sv
// Directed self-checking bench for alu_2bit (default WIDTH).
module tb_alu_2bit;
  import alu_2bit_pkg::*;

  logic                 clk;
  logic                 rst_n;
  logic                 in_valid;
  logic [ALU_WIDTH-1:0] A;
  logic [ALU_WIDTH-1:0] B;
  logic [1:0]           Op;
  logic                 out_valid;
  logic [RES_WIDTH-1:0] Y;
  logic                 zero;

  int tests;
  int fails;

  alu_2bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .Op        (Op),
    .out_valid (out_valid),
    .Y         (Y),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [RES_WIDTH-1:0] y_exp,
                     input logic z_exp, input logic v_exp);
    tests++;
    assert (Y === y_exp) else begin
      fails++;
      $error("FAIL %s Y: got %b, expected %b", tag, Y, y_exp);
    end
    tests++;
    assert (zero === z_exp) else begin
      fails++;
      $error("FAIL %s zero: got %b, expected %b", tag, zero, z_exp);
    end
    tests++;
    assert (out_valid === v_exp) else begin
      fails++;
      $error("FAIL %s out_valid: got %b, expected %b", tag, out_valid, v_exp);
    end
  endtask

  // Drive one valid op at a falling edge; check the registered result one cycle later.
  task automatic op_step(input string tag, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] op, input logic [RES_WIDTH-1:0] y_exp,
                         input logic z_exp);
    in_valid = 1'b1;
    A        = a;
    B        = b;
    Op       = op;
    @(negedge clk);
    chk(tag, y_exp, z_exp, 1'b1);
  endtask

  initial begin
    logic [1:0]           op_x;
    logic [RES_WIDTH-1:0] y_x;
    logic                 z_x;
    tests    = 0;
    fails    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    A        = '0;
    B        = '0;
    Op       = '0;

    // Reset held with random, valid-flagged inputs and a running clock.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      A  = 2'($urandom);
      B  = 2'($urandom);
      Op = 2'($urandom);
    end
    @(negedge clk);
    chk("reset_hold", 3'b000, 1'b0, 1'b0);

    // First valid input is captured on the first rising edge after release.
    rst_n = 1'b1;
    op_step("first_after_reset", 2'b01, 2'b01, OP_ADD, 3'b010, 1'b0);

    op_step("add_01_10",   2'b01, 2'b10, OP_ADD, 3'b011, 1'b0);
    op_step("add_carry",   2'b11, 2'b11, OP_ADD, 3'b110, 1'b0);
    op_step("sub_10_01",   2'b10, 2'b01, OP_SUB, 3'b001, 1'b0);
    op_step("sub_borrow",  2'b01, 2'b10, OP_SUB, 3'b111, 1'b0);
    op_step("sub_zero",    2'b10, 2'b10, OP_SUB, 3'b000, 1'b1);
    op_step("and_11_01",   2'b11, 2'b01, OP_AND, 3'b001, 1'b0);
    op_step("or_10_01",    2'b10, 2'b01, OP_OR,  3'b011, 1'b0);
    op_step("and_zero",    2'b10, 2'b01, OP_AND, 3'b000, 1'b1);

    // Unknown opcode. A two-state simulator may resolve the X literal to a known
    // value; in that case the expectation is the hand-computed result for 10 op 01.
    op_x = 2'bxx;
    if (^op_x === 1'bx) begin
      y_x = 3'b000; z_x = 1'b1;
    end else begin
      case (op_x)
        2'b00:   begin y_x = 3'b011; z_x = 1'b0; end
        2'b01:   begin y_x = 3'b001; z_x = 1'b0; end
        2'b10:   begin y_x = 3'b000; z_x = 1'b1; end
        default: begin y_x = 3'b011; z_x = 1'b0; end
      endcase
    end
    op_step("op_unknown", 2'b10, 2'b01, op_x, y_x, z_x);
    tests++;
    assert (^{Y, zero, out_valid} !== 1'bx) else begin
      fails++;
      $error("FAIL op_unknown_noX: got %b, expected no X", {Y, zero, out_valid});
    end

    // Back-to-back stream, one op per opcode, then idle.
    op_step("stream_add", 2'b01, 2'b01, OP_ADD, 3'b010, 1'b0);
    op_step("stream_sub", 2'b00, 2'b01, OP_SUB, 3'b111, 1'b0);
    op_step("stream_and", 2'b11, 2'b10, OP_AND, 3'b010, 1'b0);
    op_step("stream_or",  2'b01, 2'b10, OP_OR,  3'b011, 1'b0);
    in_valid = 1'b0;
    A        = 2'b11;
    B        = 2'b11;
    Op       = OP_ADD;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("hold_%0d", i), 3'b011, 1'b0, 1'b0);
    end

    // Asynchronous reset mid-cycle clears outputs before any clock edge.
    op_step("pre_async", 2'b11, 2'b11, OP_ADD, 3'b110, 1'b0);
    in_valid = 1'b1;
    A        = 2'b10;
    B        = 2'b01;
    Op       = OP_OR;
    #2 rst_n = 1'b0;
    #1 chk("async_reset", 3'b000, 1'b0, 1'b0);
    @(negedge clk);
    chk("reset_discard", 3'b000, 1'b0, 1'b0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", 3'b000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
